mc_ctrl_sequencer: RTL and testbench
====================================

Name: mc_ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the RISC-V core. One shared memory port serves both instruction fetch and data access; one ALU serves PC increment, address generation and arithmetic.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives every datapath enable and mux select.
- Waits on a ready handshake from memory.
- Sits between the instruction register/opcode field and the datapath. It supersedes the single-cycle opcode decode for the multi-cycle build.

Parameters:
- WAIT_MAX, 16, cycles a memory request may stall before abort; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instruction register bits [6:0]
- zero  in  1  ALU zero flag; branch taken when 1
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write request; meaningful only when mem_req=1
- i_or_d  out  1  memory address source: 0=PC, 1=ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
- reg_write  out  1  register file write
- mem_to_reg  out  2  write-back source: 0=ALUOut, 1=MDR, 2=PC (link)
- alu_src_a  out  1  ALU A source: 0=PC, 1=rs1
- alu_src_b  out  2  ALU B source: 0=rs2, 1=const 4, 2=imm
- alu_op  out  2  ALU operation: 00 add, 01 branch compare, 10 funct-decoded
- mem_timeout  out  1  one-cycle pulse on abort
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=FETCH, wait_cnt=0, instret=0, mem_timeout=0. All other outputs then take their FETCH-state values.
- rst asserted in any state, including mid-request, forces FETCH on the next edge. Pending memory handshakes are dropped; no write-enable is asserted in the reset cycle.
- States and transitions:
  - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0.
    - ir_write=pc_write=mem_ready (Mealy).
    - mem_ready=1 -> DECODE; else stay.
  - DECODE: alu_src_a=0, alu_src_b=2, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - other -> ILLEGAL handling (see Optional Feature)
  - EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10 -> ALU_WB.
  - EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=10 -> ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH; instret++.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=00 -> MEM_RD if opcode is a load, else MEM_WR.
  - MEM_RD: mem_req=1, i_or_d=1, mem_we=0; mem_ready=1 -> LOAD_WB.
  - LOAD_WB: reg_write=1, mem_to_reg=1 -> FETCH; instret++.
  - MEM_WR: mem_req=1, i_or_d=1, mem_we=1; mem_ready=1 -> FETCH; instret++.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write_cond=1 -> FETCH; instret++.
  - JAL: pc_write=1, pc_src=2, reg_write=1, mem_to_reg=2 -> FETCH; instret++.
- Defaults: any output not listed for a state is 0. opcode is stable from DECODE until return to FETCH.
- Latency, mem_ready=1 on the first request cycle:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, JAL: 3 cycles
  - each stall cycle adds 1.
- Handshake: mem_req, mem_we and i_or_d stay stable until the cycle mem_ready=1. mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Timeout (WAIT_MAX>0):
  - wait_cnt increments on each mem_req=1 & mem_ready=0 cycle and clears on any state change.
  - When wait_cnt==WAIT_MAX-1 and mem_ready=0, the next edge goes to FETCH with mem_timeout=1 for one cycle. No write enables fire; instret is unchanged.
  - mem_ready=1 in that same cycle wins: normal completion, no timeout.
- instret wraps modulo 2^CNT_W and increments exactly once per retired instruction.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP state with no enables asserted. TRAP is held until rst.
  - Extra output illegal_op (1 bit) is 1 while in TRAP; instret stops.
- Undefined:
  - Unknown opcode is a NOP: DECODE -> FETCH, no enables asserted, instret++.
  - No illegal_op port.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, JAL, TRAP)
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - ALUOp, alu_src_b, pc_src and mem_to_reg encodings
- One natural sub-module: mc_mem_wait_timer (wait counter plus timeout pulse). The FSM, output decode and instret stay in the top.

Test Plan:
- rst=1 for 2 cycles in MEM_WR with mem_req=1 -> next state FETCH; mem_we=0, instret=0, reg_write=0 throughout.
- R-type opcode 0110011, mem_ready=1 immediately -> reg_write high exactly in cycle 4, instret 0→1, back in FETCH on cycle 5.
- Load 0000011, mem_ready low 3 cycles in MEM_RD -> mem_req/i_or_d=1 held 4 cycles, reg_write with mem_to_reg=1 on cycle 8, instret+1.
- Branch 1100011 with zero=1 then zero=0 -> pc_write_cond=1 and pc_src=1 in cycle 3 both times; total 3 cycles each, instret+2.
- WAIT_MAX=4, mem_ready never asserted in FETCH -> mem_timeout pulse after 4 stall cycles, ir_write never asserted, instret unchanged.
- Opcode 1111111 -> with MC_ILLEGAL_TRAP_EN: illegal_op=1 held, no further fetch until rst. Without it: returns to FETCH on cycle 3, instret+1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Optional build macro: MC_ILLEGAL_TRAP_EN (adds the TRAP state and illegal_op port).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
        MEM_RD, LOAD_WB, MEM_WR, BRANCH, JAL, TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // State-decoded (Moore) part of the datapath control word
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Counter width able to hold 0..max_val-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    // Control word for each state; anything not listed stays 0
    function automatic ctrl_t ctrl_decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            DECODE:   c.alu_src_b = SRCB_IMM;
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_ALUOUT;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            LOAD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_MDR;
            end
            MEM_WR: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
                c.mem_we  = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RS2;
                c.alu_op        = ALU_BRANCH;
                c.pc_src        = PC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            JAL: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_JUMP;
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_PC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory stall counter: aborts a request stuck for WAIT_MAX cycles (0 = never).
module mc_mem_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic mem_ready,
    input  logic state_chg,
    output logic abort_c,
    output logic mem_timeout
);

    localparam int unsigned WCW = cnt_width(WAIT_MAX);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
    localparam bit TO_EN = (WAIT_MAX != 0);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_timeout_q, mem_timeout_d;
    logic           stall_c;

    // Count stalled request cycles; abort on the last permitted one
    always_comb begin
        stall_c       = req & ~mem_ready;
        abort_c       = TO_EN && stall_c && (wait_cnt_q == WAIT_LAST);
        mem_timeout_d = abort_c;
        wait_cnt_d    = wait_cnt_q;
        if (state_chg || abort_c) begin
            wait_cnt_d = '0;
        end else if (stall_c) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    // Counter and one-cycle timeout pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

endmodule

// File: rtl/mc_ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer.
// Optional build macro: MC_ILLEGAL_TRAP_EN (unknown opcodes trap instead of acting as NOPs).
module mc_ctrl_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_c;
    logic             abort_c;
    logic             state_chg_c;
    logic             fetch_done_c;
`ifdef MC_ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif

    // zero is consumed by the datapath's conditional PC load, not here
    logic unused_zero;
    assign unused_zero = zero;

    // Next state, retirement and next control word
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            FETCH: if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_IMM:            state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d  = FETCH;
                        retire_c = 1'b1;
`endif
                    end
                endcase
            end
            EXEC_R, EXEC_I: state_d = ALU_WB;
            MEM_ADDR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)    state_d = LOAD_WB;
                else if (abort_c) state_d = FETCH;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_d  = FETCH;
                    retire_c = 1'b1;
                end else if (abort_c) begin
                    state_d = FETCH;
                end
            end
            ALU_WB, LOAD_WB, BRANCH, JAL: begin
                state_d  = FETCH;
                retire_c = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
        state_chg_c = (state_d != state_q);
        ctrl_d      = ctrl_decode(state_d);
        instret_d   = instret_q + CNT_W'(retire_c);
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d   = (state_d == TRAP);
`endif
    end

    // State, registered control word and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ctrl_q    <= ctrl_decode(FETCH);
            instret_q <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            instret_q <= instret_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    mc_mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .req         (ctrl_q.mem_req),
        .mem_ready   (mem_ready),
        .state_chg   (state_chg_c),
        .abort_c     (abort_c),
        .mem_timeout (mem_timeout)
    );

    // Fetch completion loads IR and PC in the same cycle; reset masks every write
    assign fetch_done_c  = (state_q == FETCH) & mem_ready & ~rst;
    assign mem_req       = ctrl_q.mem_req & ~rst;
    assign mem_we        = ctrl_q.mem_we & ~rst;
    assign i_or_d        = ctrl_q.i_or_d;
    assign ir_write      = fetch_done_c;
    assign pc_write      = (ctrl_q.pc_write & ~rst) | fetch_done_c;
    assign pc_write_cond = ctrl_q.pc_write_cond & ~rst;
    assign pc_src        = ctrl_q.pc_src;
    assign reg_write     = ctrl_q.reg_write & ~rst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign instret       = instret_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op    = illegal_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// Self-checking bench for mc_ctrl_sequencer with a transaction-level reference model.
module tb_mc_ctrl_sequencer;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    localparam logic [6:0] I_R  = 7'b0110011;
    localparam logic [6:0] I_I  = 7'b0010011;
    localparam logic [6:0] I_LD = 7'b0000011;
    localparam logic [6:0] I_ST = 7'b0100011;
    localparam logic [6:0] I_BR = 7'b1100011;
    localparam logic [6:0] I_J  = 7'b1101111;

    logic clk, rst, zero, mem_ready;
    logic [6:0] opcode;
    logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write, alu_src_a, mem_timeout;
    logic [1:0] pc_src, mem_to_reg, alu_src_b, alu_op;
    logic [CNT_W-1:0] instret;
`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    mc_ctrl_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_timeout(mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       mem_timeout;
    } obs_t;

    int vec_cnt = 0;
    int err_cnt = 0;
    obs_t trace [64];
    int o_cycles, o_ir, o_pcw, o_cond, o_rw, o_wr, o_to, o_hold, o_we_bad, o_cond_bad;
    logic [1:0] o_wb;
    bit o_done;
    int e_cycles, e_ir, e_pcw, e_cond, e_rw, e_wr, e_to, e_hold;
    logic [1:0] e_wb;
    bit e_retire;
    logic [CNT_W-1:0] ref_instret;

    function automatic bit is_legal(input logic [6:0] op);
        return op == I_R || op == I_I || op == I_LD || op == I_ST || op == I_BR || op == I_J;
    endfunction

    // Reference: per-instruction cycle count and enable counts from the opcode and stall lengths
    task automatic model(input logic [6:0] op, input int fs, input int ms);
        bit r, im, ld, st, br, j, mem;
        int base;
        r = (op == I_R); im = (op == I_I); ld = (op == I_LD);
        st = (op == I_ST); br = (op == I_BR); j = (op == I_J);
        mem = ld | st;
        base = ld ? 5 : (r | im | st) ? 4 : (br | j) ? 3 : 2;
        e_ir = 0; e_pcw = 0; e_cond = 0; e_rw = 0; e_wr = 0; e_to = 0; e_hold = 0; e_wb = 2'd0;
        if (fs >= int'(WAIT_MAX)) begin
            e_cycles = int'(WAIT_MAX); e_to = 1; e_retire = 0;
        end else if (mem && ms >= int'(WAIT_MAX)) begin
            e_ir = 1; e_pcw = 1; e_cycles = fs + 3 + int'(WAIT_MAX);
            e_to = 1; e_hold = int'(WAIT_MAX); e_retire = 0;
        end else begin
            e_ir = 1; e_pcw = 1 + int'(j);
            e_cycles = base + fs + (mem ? ms : 0);
            e_rw = int'(r | im | ld | j); e_wr = int'(st); e_cond = int'(br);
            e_hold = mem ? ms + 1 : 0; e_retire = 1;
            e_wb = ld ? 2'd1 : j ? 2'd2 : 2'd0;
        end
    endtask

    // Memory-side driver: runs one instruction from a FETCH cycle until the next FETCH, recording outputs
    task automatic run_instr(input logic [6:0] op, input logic z, input int fs, input int ms, input int budget);
        int fsl, msl;
        bit left;
        opcode = op; zero = z; fsl = fs; msl = ms; left = 0;
        o_cycles = 0; o_ir = 0; o_pcw = 0; o_cond = 0; o_rw = 0; o_wr = 0; o_to = 0;
        o_hold = 0; o_we_bad = 0; o_cond_bad = 0; o_wb = 2'd3; o_done = 0;
        for (int c = 0; c < budget && c < 64; c++) begin
            if (mem_req) begin
                if (!i_or_d) begin mem_ready = (fsl == 0); if (fsl > 0) fsl--; end
                else begin mem_ready = (msl == 0); if (msl > 0) msl--; end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            trace[c] = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                        reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, mem_timeout};
            o_ir   += int'(ir_write);
            o_pcw  += int'(pc_write);
            o_cond += int'(pc_write_cond);
            o_rw   += int'(reg_write);
            if (mem_we && mem_ready) o_wr++;
            if (mem_we && !(mem_req && i_or_d)) o_we_bad++;
            if (mem_req && i_or_d) o_hold++;
            if (reg_write) o_wb = mem_to_reg;
            if (pc_write_cond && !(pc_src == 2'd1 && alu_op == 2'd1)) o_cond_bad++;
            if (!(mem_req && !i_or_d && alu_src_b == 2'd1)) left = 1;
            @(posedge clk); #1;
            o_cycles = c + 1;
            if (mem_timeout) o_to++;
            if (mem_req && !i_or_d && alu_src_b == 2'd1 && (left || mem_timeout)) begin
                o_done = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0; opcode = I_R; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({reg_write, mem_we, pc_write, ir_write, pc_write_cond} !== 5'b0)
            begin err_cnt++; $display("FAIL reset_enables got %b want 00000", {reg_write, mem_we, pc_write, ir_write, pc_write_cond}); end
        rst = 1'b0;
        #1;
        vec_cnt++;
        if ({mem_req, i_or_d, alu_src_a, alu_src_b, alu_op, pc_src} !== {1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0})
            begin err_cnt++; $display("FAIL reset_fetch_ctrl got req=%b iod=%b a=%b b=%0d op=%0d pcs=%0d", mem_req, i_or_d, alu_src_a, alu_src_b, alu_op, pc_src); end
        vec_cnt++;
        if (instret !== '0 || mem_timeout !== 1'b0)
            begin err_cnt++; $display("FAIL reset_counters got instret=%0d to=%b want 0 0", instret, mem_timeout); end
        ref_instret = '0;
        // store stopped in MEM_WR, then reset for two cycles with a ready pending
        opcode = I_ST; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if ({mem_req, mem_we, i_or_d} !== 3'b111)
            begin err_cnt++; $display("FAIL rst_setup_memwr got %b want 111", {mem_req, mem_we, i_or_d}); end
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        vec_cnt++;
        if ({mem_we, reg_write, pc_write, ir_write} !== 4'b0)
            begin err_cnt++; $display("FAIL rst_in_memwr got we/rw/pcw/irw=%b want 0000", {mem_we, reg_write, pc_write, ir_write}); end
        @(posedge clk); #1;
        vec_cnt++;
        if ({mem_we, reg_write, ir_write, pc_write, i_or_d} !== 5'b0 || instret !== '0)
            begin err_cnt++; $display("FAIL rst_second_cycle got %b instret=%0d want 00000 0", {mem_we, reg_write, ir_write, pc_write, i_or_d}, instret); end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        vec_cnt++;
        if ({mem_req, i_or_d, alu_src_b} !== {1'b1, 1'b0, 2'd1} || instret !== '0)
            begin err_cnt++; $display("FAIL rst_back_to_fetch got req=%b iod=%b b=%0d instret=%0d", mem_req, i_or_d, alu_src_b, instret); end
    endtask

    task automatic test_rtype();
        run_instr(I_R, 1'b0, 0, 0, 20);
        ref_instret = ref_instret + 1'b1;
        vec_cnt++;
        if (o_cycles !== 4 || !o_done) begin err_cnt++; $display("FAIL rtype_latency got %0d done=%0d want 4", o_cycles, o_done); end
        vec_cnt++;
        if (trace[3].reg_write !== 1'b1 || trace[3].mem_to_reg !== 2'd0 || o_rw !== 1)
            begin err_cnt++; $display("FAIL rtype_writeback got rw=%b m2r=%0d count=%0d want 1 0 1", trace[3].reg_write, trace[3].mem_to_reg, o_rw); end
        vec_cnt++;
        if ({trace[2].alu_src_a, trace[2].alu_src_b, trace[2].alu_op} !== {1'b1, 2'd0, 2'd2})
            begin err_cnt++; $display("FAIL rtype_exec_alu got a=%b b=%0d op=%0d want 1 0 2", trace[2].alu_src_a, trace[2].alu_src_b, trace[2].alu_op); end
        vec_cnt++;
        if ({trace[1].alu_src_a, trace[1].alu_src_b, trace[1].alu_op} !== {1'b0, 2'd2, 2'd0})
            begin err_cnt++; $display("FAIL decode_alu got a=%b b=%0d op=%0d want 0 2 0", trace[1].alu_src_a, trace[1].alu_src_b, trace[1].alu_op); end
        vec_cnt++;
        if ({trace[0].ir_write, trace[0].pc_write} !== 2'b11)
            begin err_cnt++; $display("FAIL fetch_mealy got irw/pcw=%b want 11", {trace[0].ir_write, trace[0].pc_write}); end
        vec_cnt++;
        if (instret !== ref_instret) begin err_cnt++; $display("FAIL rtype_instret got %0d want %0d", instret, ref_instret); end
    endtask

    task automatic test_load_stall();
        run_instr(I_LD, 1'b0, 0, 3, 30);
        ref_instret = ref_instret + 1'b1;
        vec_cnt++;
        if (o_cycles !== 8 || o_hold !== 4) begin err_cnt++; $display("FAIL load_stall got cycles=%0d hold=%0d want 8 4", o_cycles, o_hold); end
        vec_cnt++;
        if (trace[7].reg_write !== 1'b1 || trace[7].mem_to_reg !== 2'd1)
            begin err_cnt++; $display("FAIL load_wb got rw=%b m2r=%0d want 1 1", trace[7].reg_write, trace[7].mem_to_reg); end
        vec_cnt++;
        if (o_to !== 0 || instret !== ref_instret)
            begin err_cnt++; $display("FAIL load_last_wait got to=%0d instret=%0d want 0 %0d", o_to, instret, ref_instret); end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            run_instr(I_BR, (k == 0) ? 1'b1 : 1'b0, 0, 0, 20);
            ref_instret = ref_instret + 1'b1;
            vec_cnt++;
            if (o_cycles !== 3 || {trace[2].pc_write_cond, trace[2].pc_src, trace[2].alu_op, trace[2].alu_src_a, trace[2].alu_src_b} !== {1'b1, 2'd1, 2'd1, 1'b1, 2'd0})
                begin err_cnt++; $display("FAIL branch_z%0d got cycles=%0d pwc=%b pcs=%0d op=%0d", 1 - k, o_cycles, trace[2].pc_write_cond, trace[2].pc_src, trace[2].alu_op); end
        end
        vec_cnt++;
        if (instret !== ref_instret) begin err_cnt++; $display("FAIL branch_instret got %0d want %0d", instret, ref_instret); end
    endtask

    task automatic test_timeout();
        run_instr(I_R, 1'b0, 20, 0, 30);
        vec_cnt++;
        if (o_cycles !== int'(WAIT_MAX) || o_to !== 1 || o_ir !== 0)
            begin err_cnt++; $display("FAIL fetch_timeout got cycles=%0d to=%0d irw=%0d want %0d 1 0", o_cycles, o_to, o_ir, WAIT_MAX); end
        vec_cnt++;
        if (instret !== ref_instret) begin err_cnt++; $display("FAIL fetch_timeout_instret got %0d want %0d", instret, ref_instret); end
        run_instr(I_I, 1'b0, 0, 0, 20);
        ref_instret = ref_instret + 1'b1;
        vec_cnt++;
        if (trace[0].mem_timeout !== 1'b1 || trace[1].mem_timeout !== 1'b0 || o_cycles !== 4)
            begin err_cnt++; $display("FAIL timeout_pulse got %b%b cycles=%0d want 10 4", trace[0].mem_timeout, trace[1].mem_timeout, o_cycles); end
        run_instr(I_ST, 1'b0, 0, 20, 30);
        vec_cnt++;
        if (o_cycles !== 3 + int'(WAIT_MAX) || o_to !== 1 || o_wr !== 0 || instret !== ref_instret)
            begin err_cnt++; $display("FAIL store_timeout got cycles=%0d to=%0d wr=%0d instret=%0d", o_cycles, o_to, o_wr, instret); end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] op;
        int sel, fs, ms;
        ops = '{I_R, I_I, I_LD, I_ST, I_BR, I_J};
        for (int n = 0; n < 80; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            sel = $urandom_range(0, 5);
`else
            sel = $urandom_range(0, 6);
`endif
            if (sel == 6) begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end else begin
                op = ops[sel];
            end
            fs = ($urandom_range(0, 5) == 0) ? int'(WAIT_MAX) : $urandom_range(0, 3);
            ms = ($urandom_range(0, 5) == 0) ? int'(WAIT_MAX) + 1 : $urandom_range(0, 3);
            model(op, fs, ms);
            run_instr(op, 1'($urandom), fs, ms, 40);
            if (e_retire) ref_instret = ref_instret + 1'b1;
            vec_cnt++;
            if (!o_done || o_cycles !== e_cycles || o_to !== e_to || o_hold !== e_hold)
                begin err_cnt++; $display("FAIL rand%0d_timing op=%b fs=%0d ms=%0d got cyc=%0d to=%0d hold=%0d want %0d %0d %0d", n, op, fs, ms, o_cycles, o_to, o_hold, e_cycles, e_to, e_hold); end
            vec_cnt++;
            if (o_ir !== e_ir || o_pcw !== e_pcw || o_cond !== e_cond || o_rw !== e_rw || o_wr !== e_wr)
                begin err_cnt++; $display("FAIL rand%0d_enables op=%b got ir=%0d pcw=%0d cond=%0d rw=%0d wr=%0d want %0d %0d %0d %0d %0d", n, op, o_ir, o_pcw, o_cond, o_rw, o_wr, e_ir, e_pcw, e_cond, e_rw, e_wr); end
            vec_cnt++;
            if (o_we_bad !== 0 || o_cond_bad !== 0 || (e_rw != 0 && o_wb !== e_wb))
                begin err_cnt++; $display("FAIL rand%0d_muxes op=%b got we_bad=%0d cond_bad=%0d wb=%0d want 0 0 %0d", n, op, o_we_bad, o_cond_bad, o_wb, e_wb); end
            vec_cnt++;
            if (instret !== ref_instret) begin err_cnt++; $display("FAIL rand%0d_instret got %0d want %0d", n, instret, ref_instret); end
        end
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        int reqs;
        run_instr(7'b1111111, 1'b0, 0, 0, 12);
        reqs = 0;
        for (int c = 0; c < 12; c++) reqs += int'(trace[c].mem_req);
        vec_cnt++;
        if (o_done || illegal_op !== 1'b1 || reqs !== 1)
            begin err_cnt++; $display("FAIL trap_hold got done=%0d illegal=%b reqs=%0d want 0 1 1", o_done, illegal_op, reqs); end
        vec_cnt++;
        if (instret !== ref_instret) begin err_cnt++; $display("FAIL trap_instret got %0d want %0d", instret, ref_instret); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_instret = '0;
        run_instr(I_J, 1'b0, 0, 0, 20);
        ref_instret = ref_instret + 1'b1;
        vec_cnt++;
        if (illegal_op !== 1'b0 || !o_done || o_cycles !== 3 || instret !== ref_instret)
            begin err_cnt++; $display("FAIL trap_recover got illegal=%b done=%0d cyc=%0d instret=%0d", illegal_op, o_done, o_cycles, instret); end
`else
        run_instr(7'b1111111, 1'b0, 0, 0, 20);
        ref_instret = ref_instret + 1'b1;
        vec_cnt++;
        if (o_cycles !== 2 || !o_done || o_rw !== 0 || o_pcw !== 1 || o_hold !== 0 || o_cond !== 0)
            begin err_cnt++; $display("FAIL illegal_nop got cyc=%0d rw=%0d pcw=%0d hold=%0d cond=%0d want 2 0 1 0 0", o_cycles, o_rw, o_pcw, o_hold, o_cond); end
        vec_cnt++;
        if (instret !== ref_instret) begin err_cnt++; $display("FAIL illegal_instret got %0d want %0d", instret, ref_instret); end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_branch();
        test_timeout();
        test_random();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
